reg_file_param: RTL

- Parametrised successor to the fixed 4+4 x 8-bit register file in the datapath.
- Holds NUM_R general registers (R1..Rn) and NUM_T temporary registers (T1..Tn), each WIDTH bits wide.
- Applies one shared micro-operation to every register selected by one-hot-style masks in a cycle.
- Drives two independently selected, registered read ports (O1 and O2) into the ALU input muxes.
- Adds asynchronous reset, shift/rotate modes, a wrap status flag and defined behaviour for out-of-range selects.

---
 rtl/reg_file_pkg.sv | 44 ++++
 rtl/reg_file_param_if.sv | 27 ++
 rtl/reg_cell.sv | 60 ++++++
 rtl/reg_file_param.sv | 99 +++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared definitions for the parametrised register file: micro-operation codes
// and the read-index decoder that maps a flat index onto the T/R register groups.
package reg_file_pkg;

  localparam logic [2:0] FS_CLR  = 3'b000;
  localparam logic [2:0] FS_LOAD = 3'b001;
  localparam logic [2:0] FS_DEC  = 3'b010;
  localparam logic [2:0] FS_INC  = 3'b011;
  localparam logic [2:0] FS_SHL  = 3'b100;
  localparam logic [2:0] FS_SHR  = 3'b101;
  localparam logic [2:0] FS_ROL  = 3'b110;
  localparam logic [2:0] FS_ROR  = 3'b111;

  typedef enum logic [1:0] {
    GRP_T    = 2'd0,
    GRP_R    = 2'd1,
    GRP_NONE = 2'd2
  } grp_e;

  typedef struct packed {
    grp_e       grp;
    logic [2:0] pos;
  } sel_dec_t;

  // Temporaries occupy the low indices, general registers follow, the rest read as 0
  function automatic sel_dec_t decode_idx(input int idx, input int num_t, input int num_r);
    sel_dec_t res;
    int       rel;
    rel = 0;
    if (idx < num_t) begin
      res.grp = GRP_T;
      rel     = idx;
    end else if (idx < num_t + num_r) begin
      res.grp = GRP_R;
      rel     = idx - num_t;
    end else begin
      res.grp = GRP_NONE;
      rel     = 0;
    end
    res.pos = 3'(rel);
    return res;
  endfunction

endpackage

// File: rtl/reg_file_param_if.sv
// Control/data bundle between the datapath controller and the register file.
interface reg_file_param_if #(
  parameter int WIDTH = 8,
  parameter int NUM_R = 4,
  parameter int NUM_T = 4,
  parameter int SEL_W = 4
);
  logic [WIDTH-1:0] i_data;
  logic [2:0]       fun_sel;
  logic [NUM_R-1:0] r_sel;
  logic [NUM_T-1:0] t_sel;
  logic [SEL_W-1:0] o1_sel;
  logic [SEL_W-1:0] o2_sel;
  logic [WIDTH-1:0] o1;
  logic [WIDTH-1:0] o2;
  logic             wrap;

  modport master (
    output i_data, fun_sel, r_sel, t_sel, o1_sel, o2_sel,
    input  o1, o2, wrap
  );

  modport slave (
    input  i_data, fun_sel, r_sel, t_sel, o1_sel, o2_sel,
    output o1, o2, wrap
  );
endinterface

// File: rtl/reg_cell.sv
// One WIDTH-bit register applying the shared micro-operation when enabled.
// q_nxt exposes the value being written so the read ports can be write-first.
module reg_cell
  import reg_file_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       fun_sel,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_nxt,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d    = q_q;
    wrap_o = 1'b0;
    if (en) begin
      case (fun_sel)
        FS_CLR:  q_d = ZERO;
        FS_LOAD: q_d = d;
        FS_DEC:  q_d = q_q - ONE;
        FS_INC:  q_d = q_q + ONE;
        FS_SHL:  q_d = {q_q[WIDTH-2:0], 1'b0};
        FS_SHR:  q_d = {1'b0, q_q[WIDTH-1:1]};
        FS_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        FS_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
        default: q_d = q_q;
      endcase
      // Wrap looks only at the pre-edge value; shifted-out bits never count
      wrap_o = ((fun_sel == FS_DEC) && (q_q == ZERO)) ||
               ((fun_sel == FS_INC) && (q_q == ONES));
    end else begin
      q_d    = q_q;
      wrap_o = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= ZERO;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign q_nxt = q_d;

endmodule

// File: rtl/reg_file_param.sv
// NUM_T temporaries plus NUM_R general registers sharing one micro-operation,
// with two registered write-first read ports and a one-cycle wrap flag.
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NUM_R = 4,
  parameter int NUM_T = 4,
  parameter int SEL_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  reg_file_param_if.slave     bus
);

  localparam int NUM_CELLS = NUM_T + NUM_R;
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] cell_q_s  [NUM_CELLS];
  logic [WIDTH-1:0] cell_nx_s [NUM_CELLS];
  logic [NUM_CELLS-1:0] en_s;
  logic [NUM_CELLS-1:0] wrap_vec_s;
  logic [SEL_W-1:0] o1_sel_s;
  logic [SEL_W-1:0] o2_sel_s;
  sel_dec_t         dec1_s;
  sel_dec_t         dec2_s;
  int               flat1_s;
  int               flat2_s;

  logic [WIDTH-1:0] o1_q, o1_d;
  logic [WIDTH-1:0] o2_q, o2_d;
  logic             wrap_q, wrap_d;

  assign o1_sel_s = bus.o1_sel;
  assign o2_sel_s = bus.o2_sel;

  // Flat cell k < NUM_T is T(k+1); mask MSB selects the first register of a group
  for (genvar k = 0; k < NUM_T; k++) begin : g_t
    assign en_s[k] = bus.t_sel[NUM_T-1-k];
    reg_cell #(.WIDTH(WIDTH)) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en_s[k]),
      .fun_sel (bus.fun_sel),
      .d       (bus.i_data),
      .q       (cell_q_s[k]),
      .q_nxt   (cell_nx_s[k]),
      .wrap_o  (wrap_vec_s[k])
    );
  end

  for (genvar k = 0; k < NUM_R; k++) begin : g_r
    assign en_s[NUM_T+k] = bus.r_sel[NUM_R-1-k];
    reg_cell #(.WIDTH(WIDTH)) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en_s[NUM_T+k]),
      .fun_sel (bus.fun_sel),
      .d       (bus.i_data),
      .q       (cell_q_s[NUM_T+k]),
      .q_nxt   (cell_nx_s[NUM_T+k]),
      .wrap_o  (wrap_vec_s[NUM_T+k])
    );
  end

  // Read muxes pick the post-update value so a write shows up on the same edge
  always_comb begin
    o1_d    = ZERO;
    o2_d    = ZERO;
    dec1_s  = decode_idx(int'(o1_sel_s), NUM_T, NUM_R);
    dec2_s  = decode_idx(int'(o2_sel_s), NUM_T, NUM_R);
    flat1_s = (dec1_s.grp == GRP_T) ? int'(dec1_s.pos) : NUM_T + int'(dec1_s.pos);
    flat2_s = (dec2_s.grp == GRP_T) ? int'(dec2_s.pos) : NUM_T + int'(dec2_s.pos);
    for (int k = 0; k < NUM_CELLS; k++) begin
      o1_d = o1_d | (((dec1_s.grp != GRP_NONE) && (k == flat1_s)) ?
                     (en_s[k] ? cell_nx_s[k] : cell_q_s[k]) : ZERO);
      o2_d = o2_d | (((dec2_s.grp != GRP_NONE) && (k == flat2_s)) ?
                     (en_s[k] ? cell_nx_s[k] : cell_q_s[k]) : ZERO);
    end
    wrap_d = |wrap_vec_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o1_q   <= ZERO;
      o2_q   <= ZERO;
      wrap_q <= 1'b0;
    end else begin
      o1_q   <= o1_d;
      o2_q   <= o2_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.o1   = o1_q;
  assign bus.o2   = o2_q;
  assign bus.wrap = wrap_q;

endmodule
